// File: rtl/ram_model_pkg.sv
// Shared definitions for the line-granular RAM burst model: FSM encoding,
// beat-geometry helpers and the generated-pattern beat function.
package ram_model_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_BEATS = 3'd1,
    ST_WAIT     = 3'd2,
    ST_RD_BEATS = 3'd3,
    ST_WR_ACK   = 3'd4
  } ram_state_e;

  localparam int PAT_MAX_W = 128;

  function automatic int line_beats(input int line_w, input int word_w);
    return line_w / word_w;
  endfunction

  // Number of bits the beat index occupies inside the generated pattern (0 for one beat).
  function automatic int pattern_idx_w(input int beats);
    return $clog2(beats);
  endfunction

  function automatic int beat_cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  // Beat k of an unwritten line is {addr, k}; callers truncate to the beat width.
  function automatic logic [PAT_MAX_W-1:0] gen_pattern_beat(input logic [63:0] addr,
                                                            input int unsigned k,
                                                            input int unsigned k_w);
    logic [PAT_MAX_W-1:0] wide_addr;
    wide_addr = {{(PAT_MAX_W-64){1'b0}}, addr};
    return (wide_addr << k_w) | PAT_MAX_W'(k);
  endfunction

endpackage

// File: rtl/ram_burst_model_if.sv
// RAM-side port bundle of the burst model; master is the cache side.
interface ram_burst_model_if #(
  parameter int ADDR_W = 13,
  parameter int WORD_W = 16,
  parameter int LINE_W = 64
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_avalid;
  logic              ram_rnw;
  logic [WORD_W-1:0] ram_wdata;
  logic [WORD_W-1:0] ram_rdata;
  logic              ram_ack;
  logic              ram_busy;
  logic              ram_err;
  logic [LINE_W-1:0] data_backdoor;

  modport master (
    output ram_addr, ram_avalid, ram_rnw, ram_wdata,
    input  ram_rdata, ram_ack, ram_busy, ram_err, data_backdoor
  );

  modport slave (
    input  ram_addr, ram_avalid, ram_rnw, ram_wdata,
    output ram_rdata, ram_ack, ram_busy, ram_err, data_backdoor
  );
endinterface

// File: rtl/ram_line_pattern_gen.sv
// Combinational generator of the deterministic line returned for unwritten addresses.
module ram_line_pattern_gen
  import ram_model_pkg::*;
#(
  parameter int ADDR_W = 13,
  parameter int WORD_W = 16,
  parameter int LINE_W = 64
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [LINE_W-1:0] line
);
  localparam int BEATS = line_beats(LINE_W, WORD_W);
  localparam int KW    = pattern_idx_w(BEATS);

  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    assign line[k*WORD_W +: WORD_W] = WORD_W'(gen_pattern_beat(64'(addr), k, KW));
  end
endmodule

// File: rtl/ram_burst_model.sv
// Cycle-accurate line-granular RAM model behind the cache's ram_* port.
// Build option RAM_BURST_MODEL_ZERO_INIT_EN: unwritten lines read as zero instead of the pattern.
//
// state       | meaning
// ST_IDLE     | waiting for a request; only state that accepts ram_avalid
// ST_WR_BEATS | collecting write beats 1..BEATS-1
// ST_WAIT     | access latency countdown
// ST_RD_BEATS | streaming BEATS read beats with ram_ack
// ST_WR_ACK   | single write-completion ack
module ram_burst_model
  import ram_model_pkg::*;
#(
  parameter int ADDR_W  = 13,
  parameter int WORD_W  = 16,
  parameter int LINE_W  = 64,
  parameter int LATENCY = 5
) (
  input  logic               ram_clk,
  input  logic               ram_rst,
  ram_burst_model_if.slave   bus
);
  localparam int BEATS  = line_beats(LINE_W, WORD_W);
  localparam int BEAT_W = beat_cnt_w(BEATS);
  localparam int LAT_W  = $clog2(LATENCY + 1);
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  if ((LINE_W % WORD_W) != 0 || BEATS < 1) begin : g_bad_geometry
    $error("ram_burst_model: LINE_W must be a non-zero multiple of WORD_W");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("ram_burst_model: LATENCY must be at least 1");
  end

  ram_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic                rd_q, rd_d;
  logic [LINE_W-1:0]   wr_buf_q, wr_buf_d;
  logic                err_q, err_d;

  logic [LINE_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    line_valid_q;

  logic                commit;
  logic [ADDR_W-1:0]   commit_addr;
  logic [BEAT_W-1:0]   wr_slot;
  logic [LINE_W-1:0]   wr_line;
  logic [LINE_W-1:0]   fill_line;
  logic [LINE_W-1:0]   cur_line;
  logic                ack;
  logic [WORD_W-1:0]   rdata;

`ifdef RAM_BURST_MODEL_ZERO_INIT_EN
  assign fill_line = '0;
`else
  ram_line_pattern_gen #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W),
    .LINE_W (LINE_W)
  ) u_pattern (
    .addr (addr_q),
    .line (fill_line)
  );
`endif

  // Read data and backdoor both view the line at the latched address.
  assign cur_line = line_valid_q[addr_q] ? mem[addr_q] : fill_line;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beat_d      = beat_q;
    lat_d       = lat_q;
    rd_d        = rd_q;
    wr_buf_d    = wr_buf_q;
    commit      = 1'b0;
    commit_addr = addr_q;
    ack         = 1'b0;
    rdata       = '0;
    wr_slot     = (state_q == ST_WR_BEATS) ? beat_q : '0;
    wr_line     = wr_buf_q;
    wr_line[int'(wr_slot)*WORD_W +: WORD_W] = bus.ram_wdata;
    err_d       = bus.ram_avalid && (state_q != ST_IDLE) && (state_q != ST_WR_BEATS);

    case (state_q)
      ST_IDLE: begin
        if (bus.ram_avalid) begin
          addr_d = bus.ram_addr;
          rd_d   = bus.ram_rnw;
          beat_d = '0;
          lat_d  = LAT_LOAD;
          if (bus.ram_rnw) begin
            state_d = ST_WAIT;
          end else begin
            wr_buf_d = wr_line;
            if (BEATS == 1) begin
              commit      = 1'b1;
              commit_addr = bus.ram_addr;
              state_d     = ST_WAIT;
            end else begin
              beat_d  = BEAT_W'(1);
              state_d = ST_WR_BEATS;
            end
          end
        end
      end
      ST_WR_BEATS: begin
        wr_buf_d = wr_line;
        if (beat_q == LAST_BEAT) begin
          commit  = 1'b1;
          beat_d  = '0;
          state_d = ST_WAIT;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          beat_d  = '0;
          state_d = rd_q ? ST_RD_BEATS : ST_WR_ACK;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_RD_BEATS: begin
        ack   = 1'b1;
        rdata = cur_line[int'(beat_q)*WORD_W +: WORD_W];
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = ST_IDLE;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_WR_ACK: begin
        ack     = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      beat_q       <= '0;
      lat_q        <= '0;
      rd_q         <= 1'b0;
      wr_buf_q     <= '0;
      err_q        <= 1'b0;
      line_valid_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      rd_q     <= rd_d;
      wr_buf_q <= wr_buf_d;
      err_q    <= err_d;
      if (commit) begin
        line_valid_q[commit_addr] <= 1'b1;
      end
    end
  end

  // Array contents are deliberately not reset; the valid bits hide stale data.
  always_ff @(posedge ram_clk) begin
    if (commit && !ram_rst) begin
      mem[commit_addr] <= wr_line;
    end
  end

  assign bus.ram_ack       = ack;
  assign bus.ram_rdata     = rdata;
  assign bus.ram_busy      = (state_q != ST_IDLE);
  assign bus.ram_err       = err_q;
  assign bus.data_backdoor = cur_line;

endmodule

// File: tb/tb_ram_burst_model.sv
// Scoreboard bench for ram_burst_model at default parameters.
module tb_ram_burst_model;
  localparam int ADDR_W  = 13;
  localparam int WORD_W  = 16;
  localparam int LINE_W  = 64;
  localparam int LATENCY = 5;
  localparam int BEATS   = LINE_W / WORD_W;
  localparam int KW      = $clog2(BEATS);

  logic ram_clk = 1'b0;
  logic ram_rst = 1'b1;

  ram_burst_model_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) bus ();

  ram_burst_model #(
    .ADDR_W  (ADDR_W),
    .WORD_W  (WORD_W),
    .LINE_W  (LINE_W),
    .LATENCY (LATENCY)
  ) dut (
    .ram_clk (ram_clk),
    .ram_rst (ram_rst),
    .bus     (bus)
  );

  always #5 ram_clk = ~ram_clk;

  typedef struct packed {
    logic              is_rd;
    logic [WORD_W-1:0] data;
  } sb_entry_t;

  sb_entry_t         sb_q[$];
  logic [LINE_W-1:0] mem_model [int];
  int                n_cmp = 0;
  int                n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] expect_line(input int addr);
    logic [LINE_W-1:0] l;
    if (mem_model.exists(addr)) return mem_model[addr];
`ifdef RAM_BURST_MODEL_ZERO_INIT_EN
    l = '0;
`else
    for (int k = 0; k < BEATS; k++) l[k*WORD_W +: WORD_W] = WORD_W'((addr << KW) + k);
`endif
    return l;
  endfunction

  always @(negedge ram_clk) begin
    if (!ram_rst && bus.ram_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        if (e.is_rd) chk("rdata", bus.ram_rdata, e.data);
      end
    end
  end

  task automatic idle_in();
    bus.ram_avalid = 1'b0;
    bus.ram_rnw    = 1'b1;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;
  endtask

  // Caller sits 1 time unit after an edge; counts edges to ack, then ack length.
  task automatic wait_ack(input string tag, input int exp_lat, input int exp_len);
    int n = 0;
    int len = 0;
    while (bus.ram_ack !== 1'b1 && n < 40) begin
      @(posedge ram_clk); #1; n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    while (bus.ram_ack === 1'b1 && len < 40) begin
      len++;
      @(posedge ram_clk); #1;
    end
    chk({tag, "_len"}, len, exp_len);
    chk({tag, "_busy_after"}, bus.ram_busy, 0);
  endtask

  task automatic push_read(input int addr);
    logic [LINE_W-1:0] l;
    l = expect_line(addr);
    for (int k = 0; k < BEATS; k++) sb_q.push_back(sb_entry_t'{is_rd: 1'b1, data: l[k*WORD_W +: WORD_W]});
  endtask

  task automatic do_read(input int addr, input string tag);
    push_read(addr);
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b1;
    bus.ram_addr   = ADDR_W'(addr);
    @(posedge ram_clk); #1;
    bus.ram_avalid = 1'b0;
    wait_ack(tag, LATENCY, BEATS);
  endtask

  task automatic do_write(input int addr, input logic [LINE_W-1:0] line, input bit hold_av, input string tag);
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b0;
    bus.ram_addr   = ADDR_W'(addr);
    bus.ram_wdata  = line[WORD_W-1:0];
    @(posedge ram_clk); #1;
    if (!hold_av) bus.ram_avalid = 1'b0;
    for (int k = 1; k < BEATS; k++) begin
      bus.ram_wdata = line[k*WORD_W +: WORD_W];
      @(posedge ram_clk); #1;
    end
    bus.ram_avalid = 1'b0;
    mem_model[addr] = line;
    chk({tag, "_backdoor"}, bus.data_backdoor, line);
    chk({tag, "_err"}, bus.ram_err, 0);
    sb_q.push_back(sb_entry_t'{is_rd: 1'b0, data: '0});
    wait_ack(tag, LATENCY, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    idle_in();
    repeat (3) @(posedge ram_clk);
    #1;
    chk("rst_busy", bus.ram_busy, 0);
    chk("rst_ack", bus.ram_ack, 0);
    chk("rst_err", bus.ram_err, 0);
    chk("rst_rdata", bus.ram_rdata, 0);
    chk("rst_backdoor", bus.data_backdoor, expect_line(0));
    ram_rst = 1'b0;
    @(posedge ram_clk); #1;

    do_read(32'h0ABC, "rd_miss");
    do_write(32'h0ABC, 64'hDEAD_BEEF_DEAD_F00D, 1'b0, "wr_abc");
    do_read(32'h0ABC, "rd_hit");
    do_write(32'h1FFF, 64'h0123_4567_89AB_CDEF, 1'b1, "wr_top_hold");
    do_read(32'h1FFF, "rd_top");

    // Request during WAIT of a read is dropped and flagged.
    push_read(32'h0100);
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b1;
    bus.ram_addr   = ADDR_W'(32'h0100);
    @(posedge ram_clk); #1;
    bus.ram_avalid = 1'b0;
    @(posedge ram_clk); #1;
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b0;
    bus.ram_addr   = ADDR_W'(32'h0ABC);
    bus.ram_wdata  = 16'h1111;
    @(posedge ram_clk); #1;
    idle_in();
    chk("drop_err_pulse", bus.ram_err, 1);
    chk("drop_busy", bus.ram_busy, 1);
    @(posedge ram_clk); #1;
    chk("drop_err_clear", bus.ram_err, 0);
    wait_ack("drop_rd", LATENCY - 3, BEATS);
    do_read(32'h0ABC, "rd_after_drop");

    // Reset in the middle of a write burst.
    do_write(32'h0055, 64'h5555_AAAA_1234_8765, 1'b0, "wr_55");
    bus.ram_avalid = 1'b1;
    bus.ram_rnw    = 1'b0;
    bus.ram_addr   = ADDR_W'(32'h0200);
    bus.ram_wdata  = 16'hAAAA;
    @(posedge ram_clk); #1;
    bus.ram_avalid = 1'b0;
    bus.ram_wdata  = 16'hBBBB;
    @(posedge ram_clk); #1;
    ram_rst = 1'b1;
    #1;
    chk("midrst_busy", bus.ram_busy, 0);
    chk("midrst_ack", bus.ram_ack, 0);
    chk("midrst_err", bus.ram_err, 0);
    chk("midrst_rdata", bus.ram_rdata, 0);
    mem_model.delete();
    idle_in();
    @(posedge ram_clk); #1;
    ram_rst = 1'b0;
    chk("midrst_backdoor", bus.data_backdoor, expect_line(0));
    @(posedge ram_clk); #1;
    do_read(32'h0200, "rd_partial");
    do_read(32'h0055, "rd_55_reverted");
    do_read(32'h0ABC, "rd_abc_reverted");

    repeat (2) @(posedge ram_clk);
    #1;
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
